// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: clock-enable sequencer for an N-bit Gray counter.
// A debounced run button toggles between IDLE and free-running RUN. In RUN,
// clk_en pulses once every DIV cycles. A debounced step button issues a single
// enable while IDLE. tick_cnt counts every enable that is issued.
// Optional feature macro: GRAY_CHECK_EN. When it is defined, the code returned
// by the counter after each enable is checked for a single-bit change, and a
// violation latches err and blocks the sequencer until reset.
module gray_step_ctrl #(
  parameter int N         = 4,
  parameter int DIV       = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_run,
  input  logic         btn_step,
  input  logic [N-1:0] gray_in,
  output logic         clk_en,
  output logic         running,
  output logic [7:0]   tick_cnt,
  output logic         err
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES);
  localparam logic [PW-1:0]  P_TERM = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic [DBW-1:0] run_cnt;
  logic [DBW-1:0] step_cnt;
  logic           run_lvl;
  logic           step_lvl;
  logic           run_lvl_q;
  logic           step_lvl_q;
  logic           run_press;
  logic           step_press;
  logic           blocked;

  assign run_lvl  = (run_cnt == DB_MAX);
  assign step_lvl = (step_cnt == DB_MAX);

  // Debounce both buttons: count consecutive high samples, then emit one press pulse per rising level
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt    <= '0;
      step_cnt   <= '0;
      run_lvl_q  <= 1'b0;
      step_lvl_q <= 1'b0;
      run_press  <= 1'b0;
      step_press <= 1'b0;
    end else begin
      if (!btn_run)
        run_cnt <= '0;
      else if (!run_lvl)
        run_cnt <= run_cnt + 1'b1;
      if (!btn_step)
        step_cnt <= '0;
      else if (!step_lvl)
        step_cnt <= step_cnt + 1'b1;
      run_lvl_q  <= run_lvl;
      step_lvl_q <= step_lvl;
      run_press  <= run_lvl & ~run_lvl_q;
      step_press <= step_lvl & ~step_lvl_q;
    end
  end

  // Sequencer FSM: mode changes, prescaler and the registered enable pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      clk_en  <= 1'b0;
      running <= 1'b0;
    end else begin
      clk_en <= 1'b0;
      if (blocked) begin
        state   <= IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run_press) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end else if (step_press) begin
              state  <= STEP;
              clk_en <= 1'b1;
            end
          end
          RUN: begin
            if (run_press) begin
              state   <= IDLE;
              presc   <= '0;
              running <= 1'b0;
            end else begin
              presc  <= (presc == P_TERM) ? '0 : presc + 1'b1;
              clk_en <= (presc == P_TERM);
            end
          end
          STEP: begin
            state <= IDLE;
          end
          default: begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  // Count issued enables, wrapping naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt <= '0;
    else if (clk_en)
      tick_cnt <= tick_cnt + 8'd1;
  end

`ifdef GRAY_CHECK_EN
  logic [N-1:0] gray_cap;
  logic         cmp_pend;

  assign blocked = err;

  // Capture the code during each enable, then check the next code differs in exactly one bit
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_cap <= '0;
      cmp_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      cmp_pend <= clk_en;
      if (clk_en)
        gray_cap <= gray_in;
      if (cmp_pend && ($countones(gray_in ^ gray_cap) != 1))
        err <= 1'b1;
    end
  end
`else
  logic gray_unused;

  assign blocked     = 1'b0;
  assign err         = 1'b0;
  assign gray_unused = ^gray_in;
`endif

endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb_gray_step_ctrl: self-checking bench for gray_step_ctrl.
// A behavioural model tracks button hold lengths, the current mode and the
// time spent in RUN, and predicts clk_en, running, tick_cnt and err each cycle.
// Honours GRAY_CHECK_EN for the optional transition checker.
module tb_gray_step_ctrl;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int DB  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_run;
  logic         btn_step;
  logic [N-1:0] gray_in;
  logic         clk_en;
  logic         running;
  logic [7:0]   tick_cnt;
  logic         err;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int           lenRun, lenStep;
  bit           prRun, prStep;
  bit           mRunning, mStepping, mEn, mErr;
  int           mAge, mTick;
  int           grayBin = 0;
  logic [N-1:0] grayVal = '0;
  bit           grayCorrupt = 1'b0;
  bit           capPend;
  logic [N-1:0] capVal;

  typedef struct {
    bit r;
    bit run;
    bit step;
    int cycles;
    bit expRunning;
    int expPulses;
    int expTick;
  } vec_t;

  vec_t vecs [8];

  gray_step_ctrl #(.N(N), .DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .gray_in  (gray_in),
    .clk_en   (clk_en),
    .running  (running),
    .tick_cnt (tick_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] toGray(input int b);
    logic [N-1:0] v;
    v = N'(b);
    return v ^ (v >> 1);
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge
  function automatic void modelEdge(input bit r, input bit run, input bit step);
    bit oldEn  = mEn;
    bit oldErr = mErr;
    bit pr     = prRun;
    bit ps     = prStep;
    bit newErr = 1'b0;
    if (oldEn) begin
      grayBin = grayBin + 1;
      if (grayCorrupt) begin
        grayVal     = '0;
        grayBin     = 0;
        grayCorrupt = 1'b0;
      end else begin
        grayVal = toGray(grayBin);
      end
    end
    if (r) begin
      lenRun = 0; lenStep = 0; prRun = 0; prStep = 0;
      mRunning = 0; mStepping = 0; mEn = 0; mErr = 0;
      mAge = 0; mTick = 0; capPend = 0; capVal = '0;
      return;
    end
`ifdef GRAY_CHECK_EN
    if (capPend && ($countones(gray_in ^ capVal) != 1))
      newErr = 1'b1;
    capPend = oldEn;
    if (oldEn)
      capVal = gray_in;
`endif
    prRun   = (lenRun == DB);
    prStep  = (lenStep == DB);
    lenRun  = run  ? ((lenRun  > DB) ? lenRun  : lenRun  + 1) : 0;
    lenStep = step ? ((lenStep > DB) ? lenStep : lenStep + 1) : 0;
    if (oldEn)
      mTick = (mTick + 1) % 256;
    if (oldErr) begin
      mRunning = 0; mStepping = 0; mEn = 0;
    end else if (mRunning) begin
      if (pr) begin
        mRunning = 0; mEn = 0;
      end else begin
        mAge = mAge + 1;
        mEn  = ((mAge % DIV) == 0);
      end
    end else if (mStepping) begin
      mStepping = 0; mEn = 0;
    end else if (pr) begin
      mRunning = 1; mAge = 0; mEn = 0;
    end else if (ps) begin
      mStepping = 1; mEn = 1;
    end else begin
      mEn = 0;
    end
    mErr = oldErr | newErr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepClock(input bit r, input bit run, input bit step);
    rst      = r;
    btn_run  = run;
    btn_step = step;
    gray_in  = grayVal;
    @(posedge clk);
    modelEdge(r, run, step);
    @(negedge clk);
    checkOutput("clk_en", 32'(clk_en), 32'(mEn));
    checkOutput("running", 32'(running), 32'(mRunning));
    checkOutput("tick_cnt", 32'(tick_cnt), 32'(mTick));
    checkOutput("err", 32'(err), 32'(mErr));
  endtask

  task automatic applyStimulus(input vec_t v, output int pulses);
    pulses = 0;
    for (int c = 0; c < v.cycles; c++) begin
      stepClock(v.r, v.run, v.step);
      pulses = pulses + int'(clk_en);
    end
  endtask

  initial begin
    int pulses;
    int guard;
    int total;
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; gray_in = '0;

    // reset with both buttons held, fresh debounce after release, run wins over step
    vecs[0] = '{1'b1, 1'b1, 1'b1,  2, 1'b0,  0,  0};
    vecs[1] = '{1'b0, 1'b1, 1'b1,  3, 1'b0,  0,  0};
    vecs[2] = '{1'b0, 1'b1, 1'b1,  3, 1'b1,  0,  0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 80, 1'b1, 10,  9};
    vecs[4] = '{1'b0, 1'b1, 1'b0,  6, 1'b0,  0, 10};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10, 1'b0,  0, 10};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 20, 1'b0,  1, 11};
    vecs[7] = '{1'b0, 1'b0, 1'b0,  2, 1'b0,  0, 11};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], pulses);
      checkOutput($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].expRunning));
      checkOutput($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].expPulses));
      checkOutput($sformatf("vec%0d_tick", i), 32'(tick_cnt), 32'(vecs[i].expTick));
    end

    // short glitches on the run button must never register as a press
    pulses = 0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        stepClock(1'b0, 1'b1, 1'b0);
        pulses = pulses + int'(clk_en);
      end
      for (int c = 0; c < 2; c++) begin
        stepClock(1'b0, 1'b0, 1'b0);
        pulses = pulses + int'(clk_en);
      end
      checkOutput($sformatf("glitch%0d_running", g), 32'(running), 32'd0);
    end
    checkOutput("glitch_pulses", 32'(pulses), 32'd0);

    // run until tick_cnt reaches 255, then the next pulse wraps it to 0
    for (int c = 0; c < 6; c++) stepClock(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mTick != 255 && guard < 4000) begin
      stepClock(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("tick_255", 32'(tick_cnt), 32'd255);
    guard = 0;
    while (!mEn && guard < 2 * DIV) begin
      stepClock(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("wrap_pulse", 32'(clk_en), 32'd1);
    stepClock(1'b0, 1'b0, 1'b0);
    checkOutput("tick_wrap", 32'(tick_cnt), 32'd0);

    // reset in the middle of RUN right after the prescaler shows 5
    guard = 0;
    while (!(mRunning && (mAge % DIV) == 5) && guard < 2 * DIV) begin
      stepClock(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("presc5_running", 32'(running), 32'd1);
    stepClock(1'b1, 1'b0, 1'b0);
    checkOutput("midrst_clk_en", 32'(clk_en), 32'd0);
    checkOutput("midrst_running", 32'(running), 32'd0);
    checkOutput("midrst_tick", 32'(tick_cnt), 32'd0);
    stepClock(1'b0, 1'b0, 1'b0);

    // randomized button activity with occasional resets, checked against the model
    total = 0;
    while (total < 600) begin
      bit r, rn, st;
      int len;
      r   = ($urandom_range(0, 49) == 0);
      rn  = 1'($urandom_range(0, 1));
      st  = 1'($urandom_range(0, 1));
      len = r ? 1 : int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) stepClock(r, rn, st);
      total = total + len;
    end

`ifdef GRAY_CHECK_EN
    // legal 0000->0001->0011 keeps err clear, then 0011->0000 latches it
    grayBin = 0;
    grayVal = toGray(0);
    stepClock(1'b1, 1'b0, 1'b0);
    stepClock(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 6; c++) stepClock(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) stepClock(1'b0, 1'b0, 1'b0);
    end
    checkOutput("gray_legal_code", 32'(gray_in), 32'd3);
    checkOutput("gray_legal_err", 32'(err), 32'd0);
    grayCorrupt = 1'b1;
    for (int c = 0; c < 6; c++) stepClock(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) stepClock(1'b0, 1'b0, 1'b0);
    checkOutput("gray_bad_err", 32'(err), 32'd1);
    checkOutput("gray_bad_running", 32'(running), 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      stepClock(1'b0, 1'b1, 1'b0);
      pulses = pulses + int'(clk_en);
    end
    for (int c = 0; c < 8; c++) begin
      stepClock(1'b0, 1'b0, 1'b1);
      pulses = pulses + int'(clk_en);
    end
    checkOutput("gray_blocked_pulses", 32'(pulses), 32'd0);
    checkOutput("gray_blocked_err", 32'(err), 32'd1);
    stepClock(1'b1, 1'b0, 1'b0);
    checkOutput("gray_rst_err", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
